csm_nibble_seq_mult: RTL and testbench

- Sequential WIDTH x WIDTH unsigned multiplier built around one shared 4-bit carry save multiplier instance (multiCS4_v1).
- Control FSM iterates over all nibble pairs of the two operands, one pair per clock.
- Each 8-bit nibble product is shifted and accumulated into a 2*WIDTH-bit register.
- Valid/ready handshakes on input and output; used wherever a wide multiply is needed but only 4-bit multiplier area is affordable.

---
 rtl/csm_nibble_seq_mult.sv | 177 +++++++++++++++++
 tb/tb_csm_nibble_seq_mult.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csm_nibble_seq_mult.sv
// csm_nibble_seq_mult: WIDTH x WIDTH unsigned multiplier, one nibble pair per clock.
// Optional CSM_SEQ_ZERO_SKIP_EN: zero operands bypass MULT and complete at once.

module multiCS4_v1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] s;
  logic [3:0] c;
  logic [3:0] sx;
  logic [3:0] ns;
  logic [3:0] nc;
  logic [3:0] fin;
  logic       y;

  // carry-save rows; sum bit 0 retires each row, carries stay unresolved
  always_comb begin
    p   = '0;
    s   = a & {4{b[0]}};
    c   = '0;
    sx  = '0;
    ns  = '0;
    nc  = '0;
    fin = '0;
    y   = 1'b0;
    for (int r = 1; r < 4; r++) begin
      p[r-1] = s[0];
      sx = {1'b0, s[3:1]};
      for (int k = 0; k < 4; k++) begin
        y     = a[k] & b[r];
        ns[k] = sx[k] ^ y ^ c[k];
        nc[k] = (sx[k] & y) | (sx[k] & c[k]) | (y & c[k]);
      end
      s = ns;
      c = nc;
    end
    p[3]   = s[0];
    fin    = {1'b0, s[3:1]} + c;
    p[7:4] = fin;
  end
endmodule

module csm_nibble_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   factor1,
  input  logic [WIDTH-1:0]   factor2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] f1_q;
  logic [WIDTH-1:0] f1_d;
  logic [WIDTH-1:0] f2_q;
  logic [WIDTH-1:0] f2_d;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_d;
  logic [PW-1:0]    term;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    i_d;
  logic [CW-1:0]    j_q;
  logic [CW-1:0]    j_d;
  logic [CW:0]      pos;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [7:0]       pp8;
  logic             last;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (i_q == CW'(k)) nib_a = f1_q[4*k +: 4];
      if (j_q == CW'(k)) nib_b = f2_q[4*k +: 4];
    end
  end

  multiCS4_v1 u_cs4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp8)
  );

  // nibble pair (i,j) carries weight 16^(i+j)
  assign pos  = {1'b0, i_q} + {1'b0, j_q};
  assign term = PW'(pp8) << {pos, 2'b00};
  assign last = (i_q == LAST) && (j_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f1_q    <= '0;
      f2_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          f1_d    = factor1;
          f2_d    = factor2;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MULT;
`ifdef CSM_SEQ_ZERO_SKIP_EN
          if (factor1 == '0 || factor2 == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end
      end
      MULT: begin
        acc_d = acc_q + term;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = last ? '0 : i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
        // product register only moves on DONE entry
        if (last) begin
          state_d = DONE;
          prod_d  = acc_q + term;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;

endmodule

// File: tb/tb_csm_nibble_seq_mult.sv
// tb_csm_nibble_seq_mult: WIDTH 4, 8 and 16 instances driven in parallel,
// scoreboarded against plain integer multiplication.
module tb_csm_nibble_seq_mult;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst_n     = '0;
  logic [2:0]  in_valid  = '0;
  logic [2:0]  out_ready = '1;
  logic [15:0] fa [3]    = '{default: '0};
  logic [15:0] fb [3]    = '{default: '0};
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  busy;
  wire  [31:0] prod [3];

  int checks   = 0;
  int failures = 0;
  bit fin      = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : gw
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;
    wire [2*W-1:0] p;
    csm_nibble_seq_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .factor1   (fa[g][W-1:0]),
      .factor2   (fb[g][W-1:0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .product   (p),
      .busy      (busy[g])
    );
    assign prod[g] = 32'(p);
  end

  function automatic int wof(int g);
    return (g == 0) ? 4 : (g == 1) ? 8 : 16;
  endfunction

  function automatic logic [63:0] model_prod(int g, logic [15:0] a, logic [15:0] b);
    longint m  = (longint'(1) << wof(g)) - 1;
    longint am = longint'(a) & m;
    longint bm = longint'(b) & m;
    return 64'(am * bm);
  endfunction

  function automatic int model_lat(int g, logic [15:0] a, logic [15:0] b);
    int     n = wof(g) / 4;
    longint m = (longint'(1) << wof(g)) - 1;
`ifdef CSM_SEQ_ZERO_SKIP_EN
    if ((longint'(a) & m) == 0 || (longint'(b) & m) == 0) return 1;
`endif
    if (m == 0) return 0;
    return n * n + 1;
  endfunction

  task automatic chk(int g, string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL w%0d %s: got %0h want %0h", wof(g), n, act, exp);
    end
  endtask

  logic [63:0] exp_q [3][$];
  int          acc_q [3][$];
  int          lat_q [3][$];
  bit          pv    [3];
  bit          pr    [3];
  bit          rel   [3];
  bit          rchk  [3];
  logic [31:0] pp    [3];

  // monitor: acceptance pushes expectations, output handshakes pop them
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n[g]) begin
        exp_q[g].delete();
        acc_q[g].delete();
        lat_q[g].delete();
        pv[g]   = 1'b0;
        rel[g]  = 1'b0;
        rchk[g] = 1'b1;
      end else begin
        if (rchk[g]) begin
          chk(g, "reset_state",
              64'({in_ready[g], out_valid[g], busy[g], prod[g]}),
              64'({3'b100, 32'h0}));
          rchk[g] = 1'b0;
        end
        if (rel[g]) begin
          chk(g, "release",
              64'({out_valid[g], in_ready[g], busy[g]}), 64'(3'b010));
          rel[g] = 1'b0;
        end
        if (in_valid[g] && in_ready[g]) begin
          exp_q[g].push_back(model_prod(g, fa[g], fb[g]));
          acc_q[g].push_back(cyc + 1);
          lat_q[g].push_back(model_lat(g, fa[g], fb[g]));
        end
        if (out_valid[g] && !pv[g]) begin
          chk(g, "result_pending", 64'(exp_q[g].size() != 0), 64'(1));
          chk(g, "done_flags", 64'({in_ready[g], busy[g]}), 64'(2'b01));
          if (exp_q[g].size() != 0)
            chk(g, "latency", 64'(cyc + 1 - acc_q[g][0]), 64'(lat_q[g][0]));
        end
        if (out_valid[g] && pv[g] && !pr[g])
          chk(g, "stall_hold", 64'(prod[g]), 64'(pp[g]));
        if (out_valid[g] && out_ready[g] && exp_q[g].size() != 0) begin
          chk(g, "product", 64'(prod[g]), exp_q[g].pop_front());
          void'(acc_q[g].pop_front());
          void'(lat_q[g].pop_front());
          rel[g] = 1'b1;
        end
        if (fin) chk(g, "drained", 64'(exp_q[g].size()), 64'(0));
      end
      pv[g] = out_valid[g];
      pr[g] = out_ready[g];
      pp[g] = prod[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int g);
    rst_n[g] = 1'b0;
    tick();
    tick();
    rst_n[g] = 1'b1;
  endtask

  task automatic issue(int g, logic [15:0] a, logic [15:0] b, bit hold);
    fa[g]       = a;
    fb[g]       = b;
    in_valid[g] = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready[g]) break;
      if (n > 400) begin
        $display("FAIL w%0d accept_timeout: got in_ready=0 want 1", wof(g));
        $fatal(1, "accept timeout");
      end
    end
    tick();
    in_valid[g] = hold;
  endtask

  task automatic wait_out(int g, bit rnd);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (out_valid[g] && out_ready[g]) break;
      if (n > 400) begin
        $display("FAIL w%0d output_timeout: got no handshake want one", wof(g));
        $fatal(1, "output timeout");
      end
      tick();
      if (rnd) out_ready[g] = ($urandom_range(0, 2) != 0);
    end
    tick();
    out_ready[g] = 1'b1;
  endtask

  task automatic seq4();
    do_reset(0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue(0, 16'(a), 16'(b), 1'b1);
    in_valid[0] = 1'b0;
    wait_out(0, 1'b0);
  endtask

  task automatic seq8();
    logic [15:0] a;
    logic [15:0] b;
    do_reset(1);
    issue(1, 16'hFF, 16'hFF, 1'b0);
    wait_out(1, 1'b0);
    out_ready[1] = 1'b0;
    issue(1, 16'hA5, 16'h3C, 1'b0);
    fa[1]        = 16'h11;
    fb[1]        = 16'h11;
    in_valid[1]  = 1'b1;
    for (int n = 0; !out_valid[1]; n++) begin
      if (n > 50) begin
        $display("FAIL w8 stall_timeout: got out_valid=0 want 1");
        $fatal(1, "stall timeout");
      end
      tick();
    end
    repeat (6) tick();
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    wait_out(1, 1'b0);
    issue(1, 16'h7B, 16'h9C, 1'b0);
    tick();
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    issue(1, 16'h03, 16'h05, 1'b0);
    wait_out(1, 1'b0);
    issue(1, 16'h00, 16'h7B, 1'b0);
    wait_out(1, 1'b0);
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = '0;
      issue(1, a, b, 1'b0);
      wait_out(1, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic seq16();
    logic [15:0] a;
    logic [15:0] b;
    do_reset(2);
    issue(2, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_out(2, 1'b0);
    issue(2, 16'h1234, 16'h0010, 1'b0);
    wait_out(2, 1'b0);
    for (int n = 0; n < 25; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      issue(2, a, b, 1'b0);
      wait_out(2, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    fork
      seq4();
      seq8();
      seq16();
    join
    repeat (2) tick();
    fin = 1'b1;
    @(negedge clk);
    #1;
    fin = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
